lsm_sample_buffer: RTL and testbench
====================================

# lsm_sample_buffer

Downstream of the GBM step stage: captures every simulated price sample, computes its intrinsic exercise payoff against the strike, tags it with a time-step/path index and buffers it for the LSM regression stage. The GBM stage has no backpressure, so this block is the decoupling point. A valid/ready stream is offered to the consumer, and any overflow loss is flagged.

## Interface
Parameters:
- WIDTH, 32, sample/payoff word width (signed fixed point)
- QFRAC, 16, fractional bits (Q16.16)
- DEPTH, 16, FIFO entries (power of two, ≥2)
- N_STEPS, 50, time steps per path
- N_PATHS, 1024, paths per batch

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  one-cycle pulse, new sample on s_in
- s_in  in  WIDTH  simulated price S_1 (signed)
- strike  in  WIDTH  strike K (signed, quasi-static, sampled with valid_in)
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- out_s  out  WIDTH  buffered price
- out_payoff  out  WIDTH  intrinsic payoff, ≥0
- out_step  out  $clog2(N_STEPS)  step index of head
- out_path  out  $clog2(N_PATHS)  path index of head
- out_last_step  out  1  head is step N_STEPS-1
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  sticky: a sample was dropped
- batch_done  out  1  one-cycle pulse after the final sample of the batch is tagged

## Operation
- Stage 1 (capture): on valid_in, register s_in, payoff, the current step/path tags and a write strobe. Advance the tag counters on every valid_in, including samples later dropped, so tags stay aligned with the GBM sample order.
- Payoff: diff = K − S computed in WIDTH+1 bits. Negative result → 0. Result above the WIDTH-bit signed max → saturate to 0x7FFF_FFFF. No rounding.
- Tag counters: step 0..N_STEPS-1. When step wraps to 0, path increments. When path wraps from N_PATHS-1 to 0, step also wraps and batch_done pulses in the following cycle.
- Stage 2 (store): when the write strobe is set, write {s, payoff, step, path} into a circular FIFO. Write and read pointers are log2(DEPTH) bits and wrap naturally.
- Full: the write strobe arrives while count==DEPTH with no pop in the same cycle → sample discarded, overflow set, count unchanged. A simultaneous pop and write when full → write accepted, count stays DEPTH.
- Empty: out_valid=0. out_* hold the last presented values, but are only meaningful when out_valid=1.
- overflow clears only on reset.
- Reset mid-operation: all pointers, counters, the stage-1 strobe and flags clear at the next clk edge. In-flight and buffered samples are discarded.

## Timing
- Reset values: out_valid=0, out_s=0, out_payoff=0, out_step=0, out_path=0, out_last_step=0, count=0, overflow=0, batch_done=0.
- Latency: valid_in at cycle N → stage-1 register at N+1 → FIFO write at edge N+1, out_valid=1 in cycle N+2 when previously empty (first-word fall-through).
- Pop: handshake at edge M → next entry is presented in cycle M+1, or out_valid=0 if empty. count updates at the same edge.
- Throughput: one write and one read per cycle. Back-to-back valid_in is supported.
- out_valid must not depend combinationally on out_ready.

## Configuration
- LSM_PAYOFF_CALL_EN defined: payoff = max(S − K, 0) (call).
- Not defined: payoff = max(K − S, 0) (put).
- Saturation, tagging and timing are identical in both builds.

## Test plan
- Single sample, put build, K=0x0064_0000 (100.0), S=0x005A_0000 (90.0), out_ready=1 → out_valid in cycle N+2, out_payoff=0x000A_0000, step=0, path=0. Call build → payoff=0.
- S=0x0078_0000 (120.0), K=100.0, put → payoff=0. Saturation: K=0x7FFF_0000, S=0x8001_0000 → payoff=0x7FFF_FFFF.
- N_STEPS=4, N_PATHS=2, 8 back-to-back samples → tags (0,0)..(3,0),(0,1)..(3,1). out_last_step=1 on steps 3. batch_done pulses once, one cycle after the 8th sample is tagged.
- DEPTH=16, out_ready=0, 17 samples → count=16, overflow=1, 17th lost. Drain → 16 entries in order with tags 0..15.
- Full FIFO, write strobe coinciding with a pop → no overflow, count stays 16, order preserved.
- Assert rst_n=0 for one cycle with 5 entries buffered → next cycle count=0, out_valid=0, tags restart at (0,0), overflow=0.

Source files
------------

// File: rtl/lsm_sample_buffer.sv
//==============================================================================
// Module   : lsm_sample_buffer
// Captures GBM price samples, computes intrinsic payoff, tags step/path and
// buffers them in a first-word-fall-through FIFO for the LSM regression stage.
// Build option: LSM_PAYOFF_CALL_EN selects call payoff (default is put).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lsm_sample_buffer #(
    parameter int WIDTH   = 32,
    parameter int QFRAC   = 16,
    parameter int DEPTH   = 16,
    parameter int N_STEPS = 50,
    parameter int N_PATHS = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [WIDTH-1:0]           s_in,
    input  logic [WIDTH-1:0]           strike,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_s,
    output logic [WIDTH-1:0]           out_payoff,
    output logic [$clog2(N_STEPS)-1:0] out_step,
    output logic [$clog2(N_PATHS)-1:0] out_path,
    output logic                       out_last_step,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       batch_done
);

    localparam int c_STEP_W  = $clog2(N_STEPS);
    localparam int c_PATH_W  = $clog2(N_PATHS);
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = $clog2(DEPTH + 1);
    localparam int c_ENTRY_W = 2 * WIDTH + c_STEP_W + c_PATH_W;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (QFRAC >= WIDTH)) begin : g_bad_params
        $error("lsm_sample_buffer: DEPTH must be a power of two >= 2 and QFRAC < WIDTH");
    end

    // Payoff: one extra bit so K - S never wraps, then clamp to [0, signed max]
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_payoff;

`ifdef LSM_PAYOFF_CALL_EN
    assign w_diff = {s_in[WIDTH-1], s_in} - {strike[WIDTH-1], strike};
`else
    assign w_diff = {strike[WIDTH-1], strike} - {s_in[WIDTH-1], s_in};
`endif

    always_comb begin
        w_payoff = w_diff[WIDTH-1:0];
        if (w_diff[WIDTH]) begin
            w_payoff = '0;
        end else if (w_diff[WIDTH-1]) begin
            w_payoff = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    logic [c_STEP_W-1:0] r_step;
    logic [c_PATH_W-1:0] r_path;
    logic                r_s1_wr;
    logic [WIDTH-1:0]    r_s1_s;
    logic [WIDTH-1:0]    r_s1_payoff;
    logic [c_STEP_W-1:0] r_s1_step;
    logic [c_PATH_W-1:0] r_s1_path;
    logic                r_batch_done;

    // Tags advance on every valid_in, even for samples later dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step       <= '0;
            r_path       <= '0;
            r_s1_wr      <= 1'b0;
            r_s1_s       <= '0;
            r_s1_payoff  <= '0;
            r_s1_step    <= '0;
            r_s1_path    <= '0;
            r_batch_done <= 1'b0;
        end else begin
            r_s1_wr      <= valid_in;
            r_batch_done <= 1'b0;
            if (valid_in) begin
                r_s1_s      <= s_in;
                r_s1_payoff <= w_payoff;
                r_s1_step   <= r_step;
                r_s1_path   <= r_path;
                if (r_step == c_STEP_W'(N_STEPS - 1)) begin
                    r_step <= '0;
                    if (r_path == c_PATH_W'(N_PATHS - 1)) begin
                        r_path       <= '0;
                        r_batch_done <= 1'b1;
                    end else begin
                        r_path <= r_path + c_PATH_W'(1);
                    end
                end else begin
                    r_step <= r_step + c_STEP_W'(1);
                end
            end
        end
    end

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_s;
    logic [WIDTH-1:0]     r_out_payoff;
    logic [c_STEP_W-1:0]  r_out_step;
    logic [c_PATH_W-1:0]  r_out_path;

    logic                 w_pop;
    logic                 w_wr_accept;
    logic [c_PTR_W-1:0]   w_rd_ptr_nxt;
    logic [c_CNT_W-1:0]   w_count_after_pop;
    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_head_entry;

    assign w_pop             = r_out_valid && out_ready;
    assign w_wr_accept       = r_s1_wr && ((r_count != c_CNT_W'(DEPTH)) || w_pop);
    assign w_rd_ptr_nxt      = r_rd_ptr + {{(c_PTR_W-1){1'b0}}, w_pop};
    assign w_count_after_pop = r_count - {{(c_CNT_W-1){1'b0}}, w_pop};
    assign w_wr_entry        = {r_s1_s, r_s1_payoff, r_s1_step, r_s1_path};
    // When the FIFO drains to nothing, the incoming word is the next head
    assign w_head_entry      = (w_count_after_pop == '0) ? w_wr_entry : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_s      <= '0;
            r_out_payoff <= '0;
            r_out_step   <= '0;
            r_out_path   <= '0;
        end else begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_after_pop + {{(c_CNT_W-1){1'b0}}, w_wr_accept};
            r_overflow  <= r_overflow | (r_s1_wr & ~w_wr_accept);
            r_out_valid <= (w_count_after_pop != '0) || w_wr_accept;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if ((w_count_after_pop != '0) || w_wr_accept) begin
                {r_out_s, r_out_payoff, r_out_step, r_out_path} <= w_head_entry;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_s         = r_out_s;
    assign out_payoff    = r_out_payoff;
    assign out_step      = r_out_step;
    assign out_path      = r_out_path;
    assign out_last_step = (r_out_step == c_STEP_W'(N_STEPS - 1));
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign batch_done    = r_batch_done;

endmodule

`default_nettype wire

// File: tb/tb_lsm_sample_buffer.sv
//==============================================================================
// Module   : tb_lsm_sample_buffer
// Scoreboard bench for lsm_sample_buffer (small batch: 4 steps x 2 paths).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lsm_sample_buffer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 16;
    localparam int N_STEPS = 4;
    localparam int N_PATHS = 2;
    localparam logic [31:0] K100 = 32'h0064_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] s_in = '0;
    logic [31:0] strike = '0;
    logic        out_valid;
    logic [31:0] out_s;
    logic [31:0] out_payoff;
    logic [1:0]  out_step;
    logic [0:0]  out_path;
    logic        out_last_step;
    logic [4:0]  count;
    logic        overflow;
    logic        batch_done;

    lsm_sample_buffer #(
        .WIDTH(WIDTH), .QFRAC(16), .DEPTH(DEPTH), .N_STEPS(N_STEPS), .N_PATHS(N_PATHS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .s_in(s_in), .strike(strike),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .out_payoff(out_payoff), .out_step(out_step), .out_path(out_path),
        .out_last_step(out_last_step), .count(count), .overflow(overflow),
        .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [31:0] p;
        logic [1:0]  step;
        logic [0:0]  path;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_step = 0;
    int   m_path = 0;
    int   bd_cnt = 0;

    function automatic logic [31:0] exp_payoff(input logic signed [31:0] s, input logic signed [31:0] k);
        longint d;
`ifdef LSM_PAYOFF_CALL_EN
        d = longint'(s) - longint'(k);
`else
        d = longint'(k) - longint'(s);
`endif
        if (d < 0) return 32'h0;
        if (d > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        return d[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] k, input bit drop);
        exp_t e;
        valid_in = 1'b1;
        s_in     = s;
        strike   = k;
        e.s      = s;
        e.p      = exp_payoff(s, k);
        e.step   = m_step[1:0];
        e.path   = m_path[0:0];
        if (!drop) sb.push_back(e);
        m_step++;
        if (m_step == N_STEPS) begin
            m_step = 0;
            m_path = (m_path + 1) % N_PATHS;
        end
        tick();
        valid_in = 1'b0;
    endtask

    // Scoreboard: compare head against the oldest expected entry on each handshake
    always @(negedge clk) begin
        if (rst_n && batch_done) bd_cnt++;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected act=pop_with_s_%h exp=no_output", out_s);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_s, out_payoff, out_step, out_path, out_last_step} !==
                    {e.s, e.p, e.step, e.path, (e.step == 2'd3)}) begin
                    errors++;
                    $display("FAIL mon_entry act s=%h p=%h step=%0d path=%0d last=%b exp s=%h p=%h step=%0d path=%0d last=%b",
                             out_s, out_payoff, out_step, out_path, out_last_step,
                             e.s, e.p, e.step, e.path, (e.step == 2'd3));
                end
            end
        end
    end

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout act=%0d exp=0 entries left", sb.size());
        end
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty act count=%0d valid=%b exp count=0 valid=0", count, out_valid);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        sb.delete();
        m_step = 0;
        m_path = 0;
        checks++;
        if ({out_valid, out_s, out_payoff, out_step, out_path, out_last_step, count, overflow, batch_done} !== '0) begin
            errors++;
            $display("FAIL reset_state act valid=%b s=%h p=%h step=%0d path=%0d last=%b count=%0d ovf=%b bd=%b exp all 0",
                     out_valid, out_s, out_payoff, out_step, out_path, out_last_step, count, overflow, batch_done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        tick();
        do_reset();
    endtask

    task automatic test_single(input logic [31:0] s, input logic [31:0] k);
        logic [1:0] st;
        logic [0:0] pa;
        st = m_step[1:0];
        pa = m_path[0:0];
        out_ready = 1'b1;
        send(s, k, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early act valid=%b exp valid=0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_payoff !== exp_payoff(s, k) || out_step !== st || out_path !== pa) begin
            errors++;
            $display("FAIL single_head act valid=%b p=%h step=%0d path=%0d exp valid=1 p=%h step=%0d path=%0d",
                     out_valid, out_payoff, out_step, out_path, exp_payoff(s, k), st, pa);
        end
        tick();
        tick();
    endtask

    task automatic test_batch();
        int bd0;
        do_reset();
        out_ready = 1'b1;
        bd0 = bd_cnt;
        for (int i = 0; i < 8; i++) send(32'h0050_0000 + 32'(i) * 32'h0004_0000, K100, 1'b0);
        checks++;
        if (batch_done !== 1'b1) begin
            errors++;
            $display("FAIL batch_done_pulse act=%b exp=1", batch_done);
        end
        tick();
        checks++;
        if (batch_done !== 1'b0) begin
            errors++;
            $display("FAIL batch_done_clear act=%b exp=0", batch_done);
        end
        drain();
        checks++;
        if (bd_cnt - bd0 != 1) begin
            errors++;
            $display("FAIL batch_done_count act=%0d exp=1", bd_cnt - bd0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(32'h0010_0000 + 32'(i) * 32'h0001_0000, K100, i == 16);
        tick();
        tick();
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full act count=%0d ovf=%b valid=%b exp count=16 ovf=1 valid=1",
                     count, overflow, out_valid);
        end
        drain();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky act=%b exp=1", overflow);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h0020_0000 + 32'(i) * 32'h0001_0000, K100, 1'b0);
        tick();
        tick();
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL mid_prefill act count=%0d exp=5", count);
        end
        rst_n = 1'b0;
        tick();
        sb.delete();
        m_step = 0;
        m_path = 0;
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset act count=%0d valid=%b ovf=%b exp count=0 valid=0 ovf=0",
                     count, out_valid, overflow);
        end
        rst_n = 1'b1;
        test_single(32'h005A_0000, K100);
    endtask

    task automatic test_full_pop();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(32'h0030_0000 + 32'(i) * 32'h0002_0000, K100, 1'b0);
        tick();
        tick();
        checks++;
        if (count !== 5'd16) begin
            errors++;
            $display("FAIL fullpop_fill act count=%0d exp=16", count);
        end
        send(32'h0099_0000, K100, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_simul act count=%0d ovf=%b exp count=16 ovf=0", count, overflow);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single(32'h005A_0000, K100);
        test_single(32'h0078_0000, K100);
        test_single(32'h8001_0000, 32'h7FFF_0000);
        test_single(32'h7FFF_0000, 32'h8001_0000);
        test_batch();
        test_overflow();
        test_reset_mid();
        test_full_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
